// File: rtl/bilateral_frame_ctrl_if.sv
// Pixel-stream bundle between the frame sequencer, its upstream source and the bilateral9x9 filter.
// Signals: s_valid/s_pixel/s_ready (upstream valid-ready), gray_valid/gray (strobe into filter), bilat_valid (filter output strobe).
// master = sequencer side, slave = environment side (source + filter).
interface bilateral_frame_ctrl_if;
  logic       s_valid;
  logic [7:0] s_pixel;
  logic       s_ready;
  logic       gray_valid;
  logic [7:0] gray;
  logic       bilat_valid;

  modport master (
    input  s_valid, s_pixel, bilat_valid,
    output s_ready, gray_valid, gray
  );

  modport slave (
    output s_valid, s_pixel, bilat_valid,
    input  s_ready, gray_valid, gray
  );
endinterface

// File: rtl/bilateral_frame_ctrl.sv
// Frame sequencer for bilateral9x9: paces upstream pixels into gray/gray_valid, injects flush pixels, counts outputs.
// Latency: an accepted pixel appears on gray/gray_valid the next cycle; strobes are at least PIX_GAP+1 cycles apart.
// Backpressure: s_ready is registered and only high in FEED between strobes; bilat_valid cannot be stalled.
// Ports: clk, rst_n (async active-low), start, bus (bilateral_frame_ctrl_if.master),
//        busy, done, err_timeout, in_cnt, out_cnt.
module bilateral_frame_ctrl #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned PIX_GAP      = 10,
  parameter int unsigned FLUSH_PIX    = 4*IMAGE_WIDTH+4,
  parameter int unsigned TIMEOUT      = 600000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  bilateral_frame_ctrl_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic [31:0]                   in_cnt,
  output logic [31:0]                   out_cnt
);

  localparam logic [31:0] N        = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam logic [31:0] GAP_LAST = (PIX_GAP > 0) ? 32'(PIX_GAP - 1) : 32'd0;
  localparam logic [31:0] FLUSH_N  = 32'(FLUSH_PIX);
  localparam logic [31:0] TO_N     = 32'(TIMEOUT);
  localparam bit          HAS_GAP  = (PIX_GAP > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_GAP, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t      state_q;
  logic        s_ready_q, gray_valid_q, busy_q, done_q, err_q;
  logic [7:0]  gray_q;
  logic [31:0] in_cnt_q, out_cnt_q, gap_cnt_q, flush_cnt_q, to_cnt_q;

  logic        accept_d;
  logic        out_inc_d;
  logic [31:0] in_cnt_d;
  logic [31:0] to_cnt_d;

  always_comb begin
    accept_d  = (state_q == S_FEED) && s_ready_q && bus.s_valid;
    // Outputs overlap input, so counting runs in every active state; it saturates at N
    // so the extra outputs produced by the flush pixels are dropped.
    out_inc_d = (state_q != S_IDLE) && bus.bilat_valid && (out_cnt_q < N);
    in_cnt_d  = in_cnt_q + 32'd1;
    to_cnt_d  = to_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      s_ready_q    <= 1'b0;
      gray_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      gray_q       <= 8'd0;
      in_cnt_q     <= 32'd0;
      out_cnt_q    <= 32'd0;
      gap_cnt_q    <= 32'd0;
      flush_cnt_q  <= 32'd0;
      to_cnt_q     <= 32'd0;
    end else begin
      gray_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (out_inc_d) out_cnt_q <= out_cnt_q + 32'd1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            in_cnt_q    <= 32'd0;
            out_cnt_q   <= 32'd0;
            flush_cnt_q <= 32'd0;
            to_cnt_q    <= 32'd0;
            gap_cnt_q   <= 32'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            s_ready_q   <= 1'b1;
            state_q     <= S_FEED;
          end
        end

        S_FEED: begin
          if (accept_d) begin
            gray_q       <= bus.s_pixel;
            gray_valid_q <= 1'b1;
            in_cnt_q     <= in_cnt_d;
            if (HAS_GAP) begin
              s_ready_q <= 1'b0;
              gap_cnt_q <= 32'd0;
              state_q   <= S_GAP;
            end else if (in_cnt_d >= N) begin
              s_ready_q <= 1'b0;
              state_q   <= S_FLUSH;
            end
          end
        end

        // The strobe cycle itself is the first GAP cycle, so the next strobe can
        // come no earlier than PIX_GAP+1 cycles later whichever state issues it.
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= 32'd0;
            if (in_cnt_q < N) begin
              s_ready_q <= 1'b1;
              state_q   <= S_FEED;
            end else if (flush_cnt_q >= FLUSH_N) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_FLUSH;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end

        S_FLUSH: begin
          if (flush_cnt_q >= FLUSH_N) begin
            state_q <= S_DRAIN;
          end else begin
            gray_q       <= 8'd0;
            gray_valid_q <= 1'b1;
            flush_cnt_q  <= flush_cnt_q + 32'd1;
            if (HAS_GAP) begin
              gap_cnt_q <= 32'd0;
              state_q   <= S_GAP;
            end
          end
        end

        // Success is tested first so a completion coinciding with the timeout is not an error.
        S_DRAIN: begin
          to_cnt_q <= to_cnt_d;
          if (out_cnt_q == N) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (to_cnt_d >= TO_N) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.gray_valid = gray_valid_q;
  assign bus.gray       = gray_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_timeout    = err_q;
  assign in_cnt         = in_cnt_q;
  assign out_cnt        = out_cnt_q;

endmodule

// File: tb/tb_bilateral_frame_ctrl.sv
// Bench for bilateral_frame_ctrl: W=16, H=8, PIX_GAP=2, FLUSH_PIX=68, TIMEOUT=50.
// Expected gray sequence is queued per frame; a monitor pops it on every gray_valid strobe.
// A small filter model answers a budgeted number of strobes with bilat_valid.
module tb_bilateral_frame_ctrl;
  localparam int W      = 16;
  localparam int H      = 8;
  localparam int PG     = 2;
  localparam int FL     = 68;
  localparam int TO     = 50;
  localparam int NPIX   = W * H;
  localparam int NPULSE = NPIX + FL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_timeout;
  logic [31:0] in_cnt, out_cnt;

  bilateral_frame_ctrl_if bus();

  bilateral_frame_ctrl #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIX_GAP(PG), .FLUSH_PIX(FL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int frame_pulses = 0;
  int last_pulse_cyc = -1000;
  int done_seen = 0;
  int bil_budget = 0;
  bit bil_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int i);
    return 8'(i * 37 + seed * 11) | 8'h01;
  endfunction

  // Monitor: scoreboard pop and pacing check on every strobe, done pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.gray_valid) begin
        frame_pulses++;
        check("pulse_spacing_ok", 32'(cyc - last_pulse_cyc >= PG + 1), 32'd1);
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL gray_extra_pulse: got gray=%0d with no pixel expected", bus.gray);
        end else begin
          check("gray_seq", 32'(bus.gray), 32'(exp_q.pop_front()));
        end
      end
      if (rst_n && done) done_seen++;
    end
  end

  // Filter model: answers strobes with bilat_valid while budget lasts.
  initial begin
    bus.bilat_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.gray_valid && bil_budget > 0) begin
        bus.bilat_valid = 1'b1;
        bil_budget--;
      end else begin
        bus.bilat_valid = bil_force;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Offers pixels at duty% until stop_at are accepted; pulses start at cycle poke_at (-1 = never).
  task automatic feed(input int seed, input int duty, input int stop_at, input int poke_at);
    int   idx = 0;
    int   guard = 0;
    logic hs = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      if (hs) idx++;
      start = (guard == poke_at);
      if (idx >= stop_at || guard >= 4000) break;
      bus.s_valid = ($urandom_range(0, 99) < duty);
      bus.s_pixel = bus.s_valid ? pix(seed, idx) : 8'($urandom);
      hs = bus.s_valid && bus.s_ready;
      guard++;
    end
    bus.s_valid = 1'b0;
    start = 1'b0;
    if (idx < stop_at) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout: got %0d pixels accepted expected %0d", idx, stop_at);
    end
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse", budget);
    end
    dcyc = cyc;
  endtask

  task automatic run_frame(input int seed, input int duty, input int bil_n, input int poke_feed,
                           input bit drain_poke, input logic exp_err, input int exp_out, input int exp_tail);
    int d0;
    int dcyc;
    int n;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(pix(seed, i));
    for (int i = 0; i < FL; i++) exp_q.push_back(8'd0);
    frame_pulses = 0;
    bil_budget = bil_n;
    d0 = done_seen;
    pulse_start();
    check("start_clears_err", 32'(err_timeout), 32'd0);
    check("start_clears_in_cnt", in_cnt, 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    feed(seed, duty, NPIX, poke_feed);
    if (drain_poke) begin
      n = 0;
      while (frame_pulses < NPULSE && n < 2000) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      pulse_start();
    end
    wait_done(3000, dcyc);
    check("done_in_cnt", in_cnt, 32'(NPIX));
    check("done_out_cnt", out_cnt, 32'(exp_out));
    check("done_err", 32'(err_timeout), 32'(exp_err));
    check("done_busy", 32'(busy), 32'd1);
    check("pulse_total", 32'(frame_pulses), 32'(NPULSE));
    check("done_latency", 32'(dcyc - last_pulse_cyc), 32'(exp_tail));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("busy_falls", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("done_count", 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.s_valid = 1'b0;
    bus.s_pixel = 8'd0;
    #12;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_gray_valid", 32'(bus.gray_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_gray", 32'(bus.gray), 32'd0);
    check("rst_in_cnt", in_cnt, 32'd0);
    check("rst_out_cnt", out_cnt, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Full-rate frame with 20 surplus filter outputs: out_cnt saturates at N.
    run_frame(1, 100, NPIX + 20, -1, 1'b0, 1'b0, NPIX, 3);

    // bilat_valid in IDLE does not move out_cnt.
    @(posedge clk); #1; bil_force = 1'b1;
    repeat (4) @(posedge clk);
    #1; bil_force = 1'b0;
    @(negedge clk);
    check("idle_bilat_ignored", out_cnt, 32'(NPIX));

    // Sparse upstream: 30% valid duty.
    run_frame(2, 30, NPIX, -1, 1'b0, 1'b0, NPIX, 3);

    // Filter returns only 100 outputs: 50-cycle drain timeout; start pulses in FEED and DRAIN ignored.
    run_frame(3, 100, 100, 30, 1'b1, 1'b1, 100, 2 + TO);

    // Reset mid-frame at in_cnt=40.
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(pix(4, i));
    bil_budget = 1000;
    d0 = done_seen;
    pulse_start();
    check("err_cleared_by_start", 32'(err_timeout), 32'd0);
    feed(4, 100, 40, -1);
    check("pre_reset_in_cnt", in_cnt, 32'd40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_s_ready", 32'(bus.s_ready), 32'd0);
    check("arst_gray_valid", 32'(bus.gray_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_gray", 32'(bus.gray), 32'd0);
    check("arst_in_cnt", in_cnt, 32'd0);
    check("arst_out_cnt", out_cnt, 32'd0);
    exp_q.delete();
    bil_budget = 0;
    repeat (3) @(negedge clk);
    check("arst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", 32'(done_seen - d0), 32'd0);

    // Fresh frame after reset completes normally.
    run_frame(5, 100, NPIX, -1, 1'b0, 1'b0, NPIX, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bilateral_frame_ctrl.md
Name: bilateral_frame_ctrl

Overview:
Frame sequencer placed in front of bilateral9x9. It takes pixels from an upstream valid/ready stream and paces them into the filter's gray/gray_valid input with a fixed inter-pixel gap. After the last frame pixel it injects flush pixels to drain the 9x9 window pipeline. It then counts filter outputs and reports frame done, or a timeout error.

Parameters:
IMAGE_WIDTH, 320, pixels per line; must match the filter instance.
IMAGE_HEIGHT, 240, lines per frame.
PIX_GAP, 10, idle cycles inserted after every gray_valid pulse (0 = back-to-back).
FLUSH_PIX, 4*IMAGE_WIDTH+4, number of zero-valued flush pixels injected after the frame.
TIMEOUT, 600000, maximum DRAIN cycles before err_timeout.

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
s_valid  in  1  upstream pixel valid.
s_pixel  in  8  upstream pixel.
s_ready  out  1  controller accepts s_pixel this cycle.
gray_valid  out  1  one-cycle pixel strobe to filter.
gray  out  8  pixel to filter; held between strobes.
bilat_valid  in  1  filter output strobe.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on frame completion.
err_timeout  out  1  sticky; set on DRAIN timeout; cleared by next accepted start.
in_cnt  out  32  frame pixels accepted this frame.
out_cnt  out  32  filter outputs counted, saturating at IMAGE_WIDTH*IMAGE_HEIGHT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. s_ready, gray_valid, busy, done, err_timeout=0. gray=0, in_cnt=0, out_cnt=0. Gap, flush and timeout counters=0. Reset mid-frame aborts immediately; no done pulse.
- N = IMAGE_WIDTH*IMAGE_HEIGHT. All counters are 32-bit unsigned.
- IDLE: start=1 -> clear in_cnt, out_cnt, flush count, timeout count and err_timeout; go to FEED on the next cycle.
- FEED: s_ready=1, registered, asserted the cycle after entry.
  - On s_valid&s_ready: gray<=s_pixel, gray_valid=1 the next cycle only, in_cnt+1, s_ready drops the next cycle.
  - Then go to GAP if PIX_GAP>0. If PIX_GAP=0, stay in FEED, or go to FLUSH once in_cnt reaches N.
- GAP: s_ready=0, gray_valid=0 for exactly PIX_GAP cycles. Exit to FEED if in_cnt<N, else to FLUSH.
- Pixel pacing: rising edges of gray_valid are at least PIX_GAP+1 cycles apart in every state.
- FLUSH: emits FLUSH_PIX strobes with gray=0, using the same GAP pacing and an internal flush counter. After the last flush strobe plus its gap, go to DRAIN. FLUSH_PIX=0 goes straight to DRAIN. s_ready=0 throughout.
- DRAIN: timeout counter increments each cycle.
  - out_cnt==N -> DONE.
  - Timeout count reaches TIMEOUT -> set err_timeout, then DONE.
  - If both happen in the same cycle, success wins (err_timeout stays 0).
- DONE: done=1 for one cycle, busy=0 on the next cycle, state=IDLE.
- out_cnt: increments on bilat_valid in any non-IDLE state while out_cnt<N; saturates at N, so extra outputs from the flush are ignored. bilat_valid in IDLE is ignored. Counting continues in FEED, GAP and FLUSH, because outputs overlap input.
- start while busy is ignored; it does not restart the frame.
- s_valid is ignored when s_ready=0; s_pixel is sampled only on the handshake.

Test Plan:
- W=16, H=8, PIX_GAP=2, FLUSH_PIX=68, s_valid held 1 -> exactly 128+68 gray_valid pulses, each 3 cycles apart; in_cnt=128; the first 128 gray values equal the stream, the last 68 are 0.
- Same config, filter model returns 128 bilat_valid plus 20 extras -> out_cnt stops at 128; done pulses once; err_timeout=0; busy falls the cycle after done.
- s_valid toggling randomly 30% duty -> no pixel lost or duplicated (scoreboard compares gray sequence); pulse spacing ≥3 cycles.
- TIMEOUT=50, filter model emits only 100 outputs -> err_timeout=1 after 50 DRAIN cycles, done pulses, out_cnt=100. Next start clears err_timeout.
- rst_n low at in_cnt=40 -> all outputs 0 asynchronously, no done. Fresh start after release -> in_cnt counts from 0 and the full frame completes.
- start pulsed during FEED and again during DRAIN -> ignored; exactly one done per frame.
